mutex: RTL and testbench

- Registered sign classifier for a signed two's-complement word.
- Each cycle, samples `in` and drives two mutually exclusive flags: strictly positive, or strictly negative.
- Zero drives neither flag; an auxiliary zero flag covers that case.
- Used as a status/decision stage feeding downstream control logic that needs a glitch-free, one-hot-or-none sign indication.

---
 rtl/mutex.sv | 59 +++++
 tb/tb_mutex.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mutex.sv
// Registered sign classifier: one-hot-or-none positive/negative flags plus an
// auxiliary zero flag, all updated one clock after `in` is sampled.
module mutex #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   output logic             positive_flag,
   output logic             negative_flag,
   output logic             zero_flag
);

   logic             sign_bit;
   logic [WIDTH-1:0] any_set_chain;
   logic             nonzero;
   logic             positive_next;
   logic             negative_next;
   logic             zero_next;
   logic             positive_reg;
   logic             negative_reg;
   logic             zero_reg;

   assign sign_bit = in[WIDTH-1];

   // Running OR of the input bits; the last stage says whether any bit is set.
   assign any_set_chain[0] = in[0];
   generate
      for (genvar gi = 1; gi < WIDTH; gi++) begin : g_or_chain
         assign any_set_chain[gi] = any_set_chain[gi-1] | in[gi];
      end
   endgenerate

   assign nonzero = any_set_chain[WIDTH-1];

   // The three next-state terms partition the input space, so at most one is set.
   always_comb begin
      negative_next = sign_bit;
      zero_next     = ~nonzero;
      positive_next = ~sign_bit & nonzero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         positive_reg <= 1'b0;
         negative_reg <= 1'b0;
         zero_reg     <= 1'b0;
      end else begin
         positive_reg <= positive_next;
         negative_reg <= negative_next;
         zero_reg     <= zero_next;
      end
   end

   assign positive_flag = positive_reg;
   assign negative_flag = negative_reg;
   assign zero_flag     = zero_reg;

endmodule

// File: tb/tb_mutex.sv
// Self-checking bench for mutex: directed sign/boundary cases, latency and
// async reset behaviour, then randomized samples against an arithmetic model.
module tb_mutex;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] din;
   logic             positive_flag;
   logic             negative_flag;
   logic             zero_flag;

   int vectors;
   int miscompares;

   mutex #(.WIDTH(WIDTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in            (din),
      .positive_flag (positive_flag),
      .negative_flag (negative_flag),
      .zero_flag     (zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: classify by signed integer value, returned as {pos, neg, zero}.
   function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] v);
      int s;
      s = int'($signed(v));
      return {s > 0, s < 0, s == 0};
   endfunction

   function automatic logic [2:0] observed();
      return {positive_flag, negative_flag, zero_flag};
   endfunction

   // Apply a value mid-cycle, then return just after the capturing edge.
   task automatic step(input logic [WIDTH-1:0] v);
      @(negedge clk);
      din = v;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      din   = 16'd10;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (observed() !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got %b expected 000", i, observed());
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (observed() !== 3'b100) begin
         miscompares++;
         $display("FAIL reset_release: got %b expected 100", observed());
      end
      $display("test_reset: in=10 after release flags=%b", observed());
   endtask

   task automatic test_sequence();
      logic [WIDTH-1:0] seq [7];
      logic [2:0]       exp [7];
      seq = '{16'd10, 16'hFFFB, 16'h0000, 16'd12345, 16'hCFC7, 16'h7FFF, 16'h8000};
      exp = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b100, 3'b010};
      for (int i = 0; i < 7; i++) begin
         step(seq[i]);
         vectors++;
         if (observed() !== exp[i]) begin
            miscompares++;
            $display("FAIL sequence[%0d] in=%h: got %b expected %b", i, seq[i], observed(), exp[i]);
         end
         $display("test_sequence: in=%h flags=%b", seq[i], observed());
      end
   endtask

   task automatic test_edges();
      logic [WIDTH-1:0] vals [4];
      logic [2:0]       exp  [4];
      vals = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
      exp  = '{3'b100, 3'b010, 3'b100, 3'b010};
      for (int i = 0; i < 4; i++) begin
         step(vals[i]);
         vectors++;
         if (observed() !== exp[i]) begin
            miscompares++;
            $display("FAIL edge[%0d] in=%h: got %b expected %b", i, vals[i], observed(), exp[i]);
         end
         $display("test_edges: in=%h flags=%b", vals[i], observed());
      end
   endtask

   task automatic test_latency();
      step(16'd10);
      din = 16'hFFFB;
      #2;
      vectors++;
      if (observed() !== 3'b100) begin
         miscompares++;
         $display("FAIL latency_hold: got %b expected 100", observed());
      end
      @(posedge clk);
      #1;
      vectors++;
      if (observed() !== 3'b010) begin
         miscompares++;
         $display("FAIL latency_update: got %b expected 010", observed());
      end
      $display("test_latency: 10 -> -5 flags=%b", observed());
   endtask

   task automatic test_async_reset();
      step(16'hFFFB);
      vectors++;
      if (observed() !== 3'b010) begin
         miscompares++;
         $display("FAIL async_pre: got %b expected 010", observed());
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (observed() !== 3'b000) begin
         miscompares++;
         $display("FAIL async_clear: got %b expected 000", observed());
      end
      @(posedge clk);
      #1;
      vectors++;
      if (observed() !== 3'b000) begin
         miscompares++;
         $display("FAIL async_hold: got %b expected 000", observed());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (observed() !== 3'b010) begin
         miscompares++;
         $display("FAIL async_resume: got %b expected 010", observed());
      end
      $display("test_async_reset: in=-5 resumed flags=%b", observed());
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] v;
      logic [2:0]       exp;
      logic [2:0]       got;
      int               errs_before;
      errs_before = miscompares;
      for (int i = 0; i < 10000; i++) begin
         case ($urandom_range(0, 7))
            0:       v = 16'h0000;
            1:       v = 16'h8000;
            2:       v = 16'h7FFF;
            3:       v = 16'h0001;
            4:       v = 16'hFFFF;
            default: v = WIDTH'($urandom);
         endcase
         step(v);
         exp = ref_flags(v);
         got = observed();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL random[%0d] in=%h: got %b expected %b", i, v, got, exp);
         end
         vectors++;
         if ($countones(got) != 1 || (got[2] & got[1])) begin
            miscompares++;
            $display("FAIL onehot[%0d] in=%h: got %b expected exactly one set", i, v, got);
         end
      end
      $display("test_random: 10000 samples, %0d new miscompares", miscompares - errs_before);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      din         = '0;
      test_reset();
      test_sequence();
      test_edges();
      test_latency();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
